// File: rtl/hall_emulator.sv
// hall_emulator: three-phase Hall-sensor pattern generator for BLDC
// self-test and hardware-in-the-loop bring-up without a motor.
//
// Ports:
//   CLK, RST_N    clock, synchronous active-low reset
//   EN            1 = stepping, 0 = freeze everything in place
//   DIR           1 = forward (0->1->..->5), 0 = reverse
//   STEP_PERIOD   clocks per Hall state (0 = hold)
//   LOAD          strobe capturing STEP_PERIOD into the pending register
//   FAULT_SEL     00/11 normal, 01 force H=000, 10 force H=111
//   H1, H2, H3    registered Hall outputs
//   SECTOR        current sector 0..5
//   STEP          one-cycle pulse on each sector change
//   REV           one-cycle pulse on sector wrap (5->0 fwd, 0->5 rev)
//   REV_CNT       wrapping electrical-revolution counter

module hall_emulator #(
  parameter int PERIOD_W = 16,
  parameter int REV_W    = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                DIR,
  input  logic [PERIOD_W-1:0] STEP_PERIOD,
  input  logic                LOAD,
  input  logic [1:0]          FAULT_SEL,
  output logic                H1,
  output logic                H2,
  output logic                H3,
  output logic [2:0]          SECTOR,
  output logic                STEP,
  output logic                REV,
  output logic [REV_W-1:0]    REV_CNT
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } sector_e;

  sector_e             sec_q;
  sector_e             sec_d;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] per_d;
  logic [PERIOD_W-1:0] pend_q;
  logic [PERIOD_W-1:0] pend_d;
  logic [REV_W-1:0]    rev_cnt_q;
  logic [REV_W-1:0]    rev_cnt_d;
  logic [2:0]          hall_q;
  logic [2:0]          hall_d;
  logic                step_q;
  logic                step_d;
  logic                rev_q;
  logic                rev_d;
  logic                run;
  logic                bnd;
  logic                wrap;

  // {H3,H2,H1} per sector, 120 degree spacing
  function automatic logic [2:0] hall_pat(input sector_e s);
    unique case (s)
      S0:      hall_pat = 3'b001;
      S1:      hall_pat = 3'b101;
      S2:      hall_pat = 3'b100;
      S3:      hall_pat = 3'b110;
      S4:      hall_pat = 3'b010;
      S5:      hall_pat = 3'b011;
      default: hall_pat = 3'b001;
    endcase
  endfunction

  function automatic sector_e sec_fwd(input sector_e s);
    unique case (s)
      S0:      sec_fwd = S1;
      S1:      sec_fwd = S2;
      S2:      sec_fwd = S3;
      S3:      sec_fwd = S4;
      S4:      sec_fwd = S5;
      default: sec_fwd = S0;
    endcase
  endfunction

  function automatic sector_e sec_rev(input sector_e s);
    unique case (s)
      S1:      sec_rev = S0;
      S2:      sec_rev = S1;
      S3:      sec_rev = S2;
      S4:      sec_rev = S3;
      S5:      sec_rev = S4;
      default: sec_rev = S5;
    endcase
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    sec_d     = sec_q;
    per_d     = per_q;
    rev_cnt_d = rev_cnt_q;
    step_d    = 1'b0;
    rev_d     = 1'b0;

    // LOAD bypasses into the active period when it lands on a boundary
    pend_d = LOAD ? STEP_PERIOD : pend_q;

    run = EN && (per_q != '0);
    // >= rather than == so a period shortened during a freeze
    // still terminates the current state instead of wrapping CNT
    bnd = run && (cnt_q >= per_q - PERIOD_W'(1));
    wrap = DIR ? (sec_q == S5) : (sec_q == S0);

    if (run) begin
      cnt_d = bnd ? '0 : cnt_q + PERIOD_W'(1);
    end

    if (bnd) begin
      sec_d  = DIR ? sec_fwd(sec_q) : sec_rev(sec_q);
      step_d = 1'b1;
      rev_d  = wrap;
      if (wrap) begin
        rev_cnt_d = rev_cnt_q + REV_W'(1);
      end
    end

    if (bnd || (per_q == '0) || !EN) begin
      per_d = pend_d;
    end

    // fault override masks only the pins; sector keeps moving
    hall_d = hall_pat(sec_d);
    unique case (1'b1)
      FAULT_SEL == 2'b01: hall_d = 3'b000;
      FAULT_SEL == 2'b10: hall_d = 3'b111;
      default:            hall_d = hall_pat(sec_d);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sec_q     <= S0;
      cnt_q     <= '0;
      per_q     <= '0;
      pend_q    <= '0;
      rev_cnt_q <= '0;
      hall_q    <= 3'b001;
      step_q    <= 1'b0;
      rev_q     <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      pend_q    <= pend_d;
      rev_cnt_q <= rev_cnt_d;
      hall_q    <= hall_d;
      step_q    <= step_d;
      rev_q     <= rev_d;
    end
  end

  assign {H3, H2, H1} = hall_q;
  assign SECTOR       = sec_q;
  assign STEP         = step_q;
  assign REV          = rev_q;
  assign REV_CNT      = rev_cnt_q;

endmodule

// File: doc/hall_emulator.md
# hall_emulator

Synthesizable three-phase Hall-sensor pattern generator. It produces the H1/H2/H3 commutation sequence that the BLDC controller consumes. It closes the loop in on-FPGA self-test and hardware-in-the-loop bring-up without a motor, acting as the transmitting end of the Hall-sensor interface. Step rate, direction and fault patterns are runtime-programmable, and the block reports step and electrical-revolution events.

## Interface
Parameters:
- PERIOD_W, 16, width of step-period register and counter
- REV_W, 16, width of electrical-revolution counter

Ports:
- CLK  in  1  system clock (50 MHz nominal)
- RST_N  in  1  reset; one clock; reset is synchronous and active-low
- EN  in  1  1 = stepping enabled; 0 = freeze sequence
- DIR  in  1  1 = forward, 0 = reverse
- STEP_PERIOD  in  PERIOD_W  clocks per Hall state; 0 = hold
- LOAD  in  1  one-cycle strobe, captures STEP_PERIOD
- FAULT_SEL  in  2  00 normal, 01 force 000, 10 force 111, 11 normal
- H1, H2, H3  out  1 each  emulated Hall outputs, registered
- SECTOR  out  3  current sector 0..5
- STEP  out  1  one-cycle pulse on each sector change
- REV  out  1  one-cycle pulse on sector wrap
- REV_CNT  out  REV_W  electrical revolutions completed, wraps

## Operation
- Sector-to-pattern mapping {H3,H2,H1}: 0→001, 1→101, 2→100, 3→110, 4→010, 5→011. This is 120° spacing; exactly one bit changes per step.
- Forward: sector 0→1→…→5→0. Reverse: 0→5→4→…→1→0.
- Period handling:
  - LOAD writes STEP_PERIOD into a pending register.
  - The active period takes the pending value at the next step boundary, or immediately when the active period is 0 or EN=0.
  - Mid-state period changes therefore never truncate the current state.
- Step counter CNT runs only when EN=1 and active period P≠0.
  - When CNT==P−1: CNT←0, sector advances per DIR, STEP=1.
  - Otherwise CNT←CNT+1.
- DIR is sampled at the step boundary. A DIR change mid-state does not reset CNT and affects only the next transition.
- REV pulses and REV_CNT increments on a forward 5→0 or a reverse 0→5 transition. REV_CNT wraps from 2^REV_W−1 to 0.
- EN=0:
  - CNT, sector, H outputs and REV_CNT hold.
  - STEP and REV are 0.
  - When EN returns to 1, counting resumes from the held CNT.
- FAULT_SEL overrides only the H outputs, with 1-cycle latency. SECTOR, CNT, STEP and REV keep advancing underneath. Returning to 00 restores the current sector pattern on the next clock.
- Reset (RST_N=0 sampled on a CLK edge):
  - SECTOR=0, {H3,H2,H1}=001.
  - CNT=0, active and pending period=0.
  - STEP=0, REV=0, REV_CNT=0.
  - Reset asserted mid-state aborts immediately with no partial step.
  - After reset, the block holds until a LOAD with nonzero STEP_PERIOD.
- LOAD coinciding with a step boundary: the new value becomes active for the state that starts on that edge.

## Timing
- All outputs are registered.
- H1..H3, SECTOR, STEP and REV update on the same CLK edge as the sector change.
- With active period P≥1, every Hall state lasts exactly P clocks, and an electrical revolution is 6·P clocks.
- P=1 toggles one Hall bit every clock, and STEP stays high continuously.
- From EN rising, with P loaded and CNT=0, the first step occurs P clocks later.
- LOAD while idle (P=0, or EN=0) makes the value active on the next clock. The first step then follows P clocks after that, provided EN=1.
- FAULT_SEL affects H outputs 1 clock after it is sampled.

## Test plan
- Forward, nominal rate:
  - Stimulus: RST_N released, LOAD STEP_PERIOD=50, EN=1, DIR=1.
  - Response: {H3,H2,H1} sequence 001,101,100,110,010,011, each state exactly 50 clocks (1000 ns). REV pulses every 300 clocks. REV_CNT=3 after 900 clocks.
- Reverse and direction change:
  - Stimulus: forward run, DIR→0 at clock 20 of sector 2.
  - Response: at clock 50 of that state the sector goes 2→1 (pattern 101). Further steps 1→0→5 produce REV on the 0→5 transition.
- Period reload:
  - Stimulus: P=50, LOAD 10 at clock 5 of a state.
  - Response: that state still lasts 50 clocks; all following states last 10 clocks.
- Enable freeze:
  - Stimulus: EN=0 at CNT=30 for 100 clocks, then EN=1.
  - Response: outputs and SECTOR constant, STEP=0 while frozen. The next step occurs 20 clocks after EN=1.
- Fault injection:
  - Stimulus: FAULT_SEL=01 for 75 clocks, then 10, then 00.
  - Response: H=000, then 111, 1 clock after each change. After 00, H equals the pattern of the current SECTOR, which has advanced normally underneath.
- Reset mid-operation and edge values:
  - Stimulus: assert RST_N=0 at sector 4, CNT=17.
  - Response: next clock shows SECTOR=0, H=001, REV_CNT=0, and the block holds.
  - Stimulus: P=1.
  - Response: one Hall transition per clock.
  - Stimulus: REV_CNT preloaded near wrap by running.
  - Response: wraps to 0.
